// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a registered-read FIFO and serializes
// each one as a UART frame (start, 8 data LSB first, opt parity, stop).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
  localparam int CW       = $clog2(STOP_LEN + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t BIT_LAST  = cnt_t'(CLKS_PER_BIT - 1);
  localparam cnt_t STOP_LAST = cnt_t'(STOP_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [7:0] count_q, count_d;
  logic       tx_q, tx_d;
  logic       rd_q, rd_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       go;

  assign go = tx_enable && !fifo_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (go) state_d = POP;
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = fifo_data;
        par_d   = ^fifo_data;
        cnt_d   = '0;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d   = '0;
          count_d = count_q + 8'd1;
          state_d = go ? POP : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    rd_d   = (state_d == POP);
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (cnt_d == STOP_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      count_q <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      count_q <= count_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_rd_en  = rd_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two DUTs (8N1 and 8E2, 4 clocks/bit) fed by queue FIFOs;
// tx waveforms are checked against frames built from the byte values.
module tb_fifo_uart_tx;

  localparam int CPB  = 4;
  localparam int MAXC = 32768;
  localparam int F0   = 10 * CPB;
  localparam int F1   = 12 * CPB;

  logic clk;
  logic rst;
  logic en0, fe0, rd0, tx0, busy0, done0;
  logic en1, fe1, rd1, tx1, busy1, done1;
  logic [7:0] fd0, cnt0, fd1, cnt1;

  int cyc;
  int n_cmp, n_err;
  int rdn0, rdn1, donen0, donen1, uf0, uf1;
  int exp_cnt0, exp_cnt1;

  byte unsigned q0[$];
  byte unsigned q1[$];
  byte unsigned sent[$];
  bit exp_w[$];

  logic [11:0] lg0 [MAXC];
  logic [11:0] lg1 [MAXC];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_enable(en0), .fifo_empty(fe0),
    .fifo_data(fd0), .fifo_rd_en(rd0), .tx(tx0), .busy(busy0),
    .frame_done(done0), .frame_count(cnt0)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .tx_enable(en1), .fifo_empty(fe1),
    .fifo_data(fd1), .fifo_rd_en(rd1), .tx(tx1), .busy(busy1),
    .frame_done(done1), .frame_count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rd0 === 1'b1) begin
      rdn0++;
      if (q0.size() == 0) uf0++;
      else fd0 <= q0.pop_front();
    end
    if (rd1 === 1'b1) begin
      rdn1++;
      if (q1.size() == 0) uf1++;
      else fd1 <= q1.pop_front();
    end
    if (done0 === 1'b1) donen0++;
    if (done1 === 1'b1) donen1++;
  end

  always @(negedge clk) begin
    fe0 = (q0.size() == 0);
    fe1 = (q1.size() == 0);
    if (cyc < MAXC) begin
      lg0[cyc] = {cnt0, busy0, done0, rd0, tx0};
      lg1[cyc] = {cnt1, busy1, done1, rd1, tx1};
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add_level(input bit v, input int n);
    repeat (n) exp_w.push_back(v);
  endtask

  task automatic add_frame(input byte unsigned b, input bit par_en,
                           input int stops);
    add_level(1'b0, CPB);
    for (int i = 0; i < 8; i++) add_level(b[i], CPB);
    if (par_en) add_level(bit'($countones(b) % 2), CPB);
    add_level(1'b1, stops * CPB);
  endtask

  task automatic wait_done(input bit sel, input int target,
                           input int budget, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < budget) begin
      if ((sel ? donen1 : donen0) >= target) begin
        ok = 1'b1;
        break;
      end
      tick(1);
      n++;
    end
  endtask

  task automatic scan(input bit sel, input int b, input int from,
                      input int to, input logic lvl,
                      output int n, output int first);
    logic v;
    n = 0;
    first = -1;
    for (int c = from; c < to; c++) begin
      v = sel ? lg1[c][b] : lg0[c][b];
      if (v === lvl) begin
        if (first < 0) first = c;
        n++;
      end
    end
  endtask

  task automatic trace_diff(input bit sel, input int s,
                            output int bad, output int first);
    logic t;
    bad = 0;
    first = -1;
    foreach (exp_w[i]) begin
      t = sel ? lg1[s+i][0] : lg0[s+i][0];
      if (t !== exp_w[i]) begin
        if (first < 0) first = i;
        bad++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en0 = 1'b0;
    en1 = 1'b0;
    tick(3);
    n_cmp++;
    if ({tx0, busy0, rd0, done0, cnt0} !== 12'h800) begin
      n_err++;
      $display("FAIL reset0: got %h expected 800",
               {tx0, busy0, rd0, done0, cnt0});
    end
    n_cmp++;
    if ({tx1, busy1, rd1, done1, cnt1} !== 12'h800) begin
      n_err++;
      $display("FAIL reset1: got %h expected 800",
               {tx1, busy1, rd1, done1, cnt1});
    end
    rst = 1'b0;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    en0 = 1'b1;
    tick(20);
    n_cmp++;
    if ({tx0, busy0, rdn0} !== {1'b1, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL idle_empty: tx=%b busy=%b pops=%0d expected 1 0 0",
               tx0, busy0, rdn0);
    end
  endtask

  task automatic test_single;
    int p, s, d0, r0, n, first, bad;
    bit ok;
    d0 = donen0;
    r0 = rdn0;
    p = cyc;
    s = p + 3;
    q0.push_back(8'hA5);
    wait_done(1'b0, d0 + 1, 200, ok);
    tick(4);
    exp_cnt0 = (exp_cnt0 + 1) % 256;
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL single_timeout: frame_done count %0d expected %0d",
               donen0, d0 + 1);
    end
    scan(1'b0, 1, p - 1, s + F0 + 2, 1'b1, n, first);
    n_cmp++;
    if ({n, first} !== {32'd1, p + 1}) begin
      n_err++;
      $display("FAIL single_rd: %0d pulses first at %0d expected 1 at %0d",
               n, first, p + 1);
    end
    scan(1'b0, 0, p, p + 10, 1'b0, n, first);
    n_cmp++;
    if (first !== s) begin
      n_err++;
      $display("FAIL single_latency: tx fell at %0d expected %0d", first, s);
    end
    exp_w.delete();
    add_frame(8'hA5, 1'b0, 1);
    add_level(1'b1, 2);
    trace_diff(1'b0, s, bad, first);
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL single_wave: %0d bad cycles first at +%0d expected 0",
               bad, first);
    end
    scan(1'b0, 2, p, s + F0 + 2, 1'b1, n, first);
    n_cmp++;
    if ({n, first} !== {32'd1, s + F0 - 1}) begin
      n_err++;
      $display("FAIL single_done: %0d pulses at %0d expected 1 at %0d",
               n, first, s + F0 - 1);
    end
    n_cmp++;
    if ({cnt0, 32'(rdn0 - r0)} !== {8'(exp_cnt0), 32'd1}) begin
      n_err++;
      $display("FAIL single_count: count=%0d pops=%0d expected %0d 1",
               cnt0, rdn0 - r0, exp_cnt0);
    end
  endtask

  task automatic test_reset_mid;
    int p, d0;
    p = cyc;
    q0.push_back(8'h00);
    tick(p + 12 - cyc);
    n_cmp++;
    if ({tx0, busy0} !== 2'b01) begin
      n_err++;
      $display("FAIL mid_predata: tx=%b busy=%b expected 0 1", tx0, busy0);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({tx0, busy0, rd0, done0, cnt0} !== 12'h800) begin
      n_err++;
      $display("FAIL mid_reset: got %h expected 800",
               {tx0, busy0, rd0, done0, cnt0});
    end
    en0 = 1'b0;
    d0 = donen0;
    tick(2);
    rst = 1'b0;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    tick(60);
    n_cmp++;
    if ({32'(donen0 - d0), tx0, busy0} !== {32'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL mid_after: done=%0d tx=%b busy=%b expected 0 1 0",
               donen0 - d0, tx0, busy0);
    end
  endtask

  task automatic test_parity;
    int p, s, d1, n, first, bad;
    bit ok;
    d1 = donen1;
    p = cyc;
    s = p + 3;
    q1.push_back(8'h07);
    en1 = 1'b1;
    wait_done(1'b1, d1 + 1, 200, ok);
    tick(4);
    exp_cnt1 = (exp_cnt1 + 1) % 256;
    exp_w.delete();
    add_frame(8'h07, 1'b1, 2);
    add_level(1'b1, 2);
    trace_diff(1'b1, s, bad, first);
    n_cmp++;
    if (ok !== 1'b1 || bad !== 0) begin
      n_err++;
      $display("FAIL parity_wave: ok=%b %0d bad cycles at +%0d expected 0",
               ok, bad, first);
    end
    scan(1'b1, 2, p, s + F1 + 2, 1'b1, n, first);
    n_cmp++;
    if ({n, first} !== {32'd1, s + F1 - 1}) begin
      n_err++;
      $display("FAIL parity_len: %0d pulses at %0d expected 1 at %0d",
               n, first, s + F1 - 1);
    end
    n_cmp++;
    if (cnt1 !== 8'(exp_cnt1)) begin
      n_err++;
      $display("FAIL parity_count: got %0d expected %0d", cnt1, exp_cnt1);
    end
  endtask

  task automatic test_back_to_back;
    int e, s, d0, r0, n, first, bad;
    bit ok, want;
    en0 = 1'b0;
    d0 = donen0;
    r0 = rdn0;
    q0.push_back(8'h11);
    q0.push_back(8'h22);
    q0.push_back(8'h33);
    tick(3);
    e = cyc;
    s = e + 3;
    en0 = 1'b1;
    wait_done(1'b0, d0 + 3, 400, ok);
    tick(25);
    exp_cnt0 = (exp_cnt0 + 3) % 256;
    exp_w.delete();
    add_frame(8'h11, 1'b0, 1);
    add_level(1'b1, 2);
    add_frame(8'h22, 1'b0, 1);
    add_level(1'b1, 2);
    add_frame(8'h33, 1'b0, 1);
    add_level(1'b1, 20);
    trace_diff(1'b0, s, bad, first);
    n_cmp++;
    if (ok !== 1'b1 || bad !== 0) begin
      n_err++;
      $display("FAIL b2b_wave: ok=%b %0d bad cycles at +%0d expected 0",
               ok, bad, first);
    end
    bad = 0;
    for (int c = e - 2; c < s + 144; c++) begin
      want = (c == e + 1) || (c == e + 43) || (c == e + 85);
      if (lg0[c][1] !== want) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL b2b_rd: %0d misplaced pop cycles expected 0", bad);
    end
    n_cmp++;
    if ({cnt0, 32'(rdn0 - r0), uf0} !== {8'(exp_cnt0), 32'd3, 32'd0}) begin
      n_err++;
      $display("FAIL b2b_count: count=%0d pops=%0d underflow=%0d expected %0d 3 0",
               cnt0, rdn0 - r0, uf0, exp_cnt0);
    end
  endtask

  task automatic test_enable_drop;
    int e, s, f, d0, r0, n, first, bad;
    bit ok;
    en0 = 1'b0;
    d0 = donen0;
    r0 = rdn0;
    q0.push_back(8'h5A);
    q0.push_back(8'hC3);
    tick(3);
    e = cyc;
    s = e + 3;
    en0 = 1'b1;
    tick(s + 10 - cyc);
    en0 = 1'b0;
    wait_done(1'b0, d0 + 1, 200, ok);
    tick(45);
    exp_cnt0 = (exp_cnt0 + 1) % 256;
    exp_w.delete();
    add_frame(8'h5A, 1'b0, 1);
    add_level(1'b1, 40);
    trace_diff(1'b0, s, bad, first);
    n_cmp++;
    if (ok !== 1'b1 || bad !== 0) begin
      n_err++;
      $display("FAIL drop_wave: ok=%b %0d bad cycles at +%0d expected 0",
               ok, bad, first);
    end
    scan(1'b0, 1, e - 2, s + 80, 1'b1, n, first);
    n_cmp++;
    if ({n, first, busy0} !== {32'd1, e + 1, 1'b0}) begin
      n_err++;
      $display("FAIL drop_idle: %0d pops first %0d busy=%b expected 1 %0d 0",
               n, first, busy0, e + 1);
    end
    f = cyc;
    s = f + 3;
    en0 = 1'b1;
    wait_done(1'b0, d0 + 2, 200, ok);
    tick(5);
    exp_cnt0 = (exp_cnt0 + 1) % 256;
    exp_w.delete();
    add_frame(8'hC3, 1'b0, 1);
    add_level(1'b1, 2);
    trace_diff(1'b0, s, bad, first);
    scan(1'b0, 1, f - 1, s + F0, 1'b1, n, first);
    n_cmp++;
    if (ok !== 1'b1 || bad !== 0 || n !== 1 || first !== f + 1) begin
      n_err++;
      $display("FAIL drop_resume: ok=%b bad=%0d pops=%0d at %0d expected 1 0 1 %0d",
               ok, bad, n, first, f + 1);
    end
    n_cmp++;
    if ({cnt0, 32'(rdn0 - r0)} !== {8'(exp_cnt0), 32'd2}) begin
      n_err++;
      $display("FAIL drop_count: count=%0d pops=%0d expected %0d 2",
               cnt0, rdn0 - r0, exp_cnt0);
    end
  endtask

  task automatic test_wrap;
    int e, s, d0, r0, first, bad;
    byte unsigned b;
    bit ok;
    rst = 1'b1;
    en0 = 1'b0;
    tick(2);
    rst = 1'b0;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    d0 = donen0;
    r0 = rdn0;
    exp_w.delete();
    for (int k = 0; k < 256; k++) begin
      b = 8'($urandom);
      q0.push_back(b);
      add_frame(b, 1'b0, 1);
      add_level(1'b1, 2);
    end
    tick(2);
    e = cyc;
    s = e + 3;
    en0 = 1'b1;
    wait_done(1'b0, d0 + 256, 256 * 42 + 200, ok);
    tick(5);
    exp_cnt0 = (exp_cnt0 + 256) % 256;
    trace_diff(1'b0, s, bad, first);
    n_cmp++;
    if (ok !== 1'b1 || bad !== 0) begin
      n_err++;
      $display("FAIL wrap_wave: ok=%b %0d bad cycles at +%0d expected 0",
               ok, bad, first);
    end
    n_cmp++;
    if (lg0[s + 255 * 42 + F0 - 1][11:4] !== 8'd255) begin
      n_err++;
      $display("FAIL wrap_pre: count %0d expected 255",
               lg0[s + 255 * 42 + F0 - 1][11:4]);
    end
    n_cmp++;
    if ({cnt0, 32'(donen0 - d0), 32'(rdn0 - r0), uf0}
        !== {8'(exp_cnt0), 32'd256, 32'd256, 32'd0}) begin
      n_err++;
      $display("FAIL wrap_count: count=%0d done=%0d pops=%0d uf=%0d expected %0d 256 256 0",
               cnt0, donen0 - d0, rdn0 - r0, uf0, exp_cnt0);
    end
  endtask

  task automatic test_random_parity;
    int nb, bgn, d1, i, k;
    byte unsigned b, got;
    bit p, st, ok;
    nb = $urandom_range(6, 12);
    d1 = donen1;
    bgn = cyc;
    en1 = 1'b1;
    sent.delete();
    for (int j = 0; j < nb; j++) begin
      b = 8'($urandom);
      sent.push_back(b);
      q1.push_back(b);
      tick($urandom_range(0, 70));
    end
    wait_done(1'b1, d1 + nb, nb * 60 + 200, ok);
    tick(3);
    exp_cnt1 = (exp_cnt1 + nb) % 256;
    i = bgn;
    k = 0;
    while (i + F1 <= cyc && k < nb) begin
      if (lg1[i][0] === 1'b0) begin
        got = 8'h00;
        for (int j = 0; j < 8; j++) got[j] = lg1[i + (1 + j) * CPB + CPB / 2][0];
        p  = lg1[i + 9 * CPB + CPB / 2][0];
        st = lg1[i + 10 * CPB + CPB / 2][0] & lg1[i + 11 * CPB + CPB / 2][0];
        n_cmp++;
        if ({got, p, st} !== {sent[k], bit'($countones(sent[k]) % 2), 1'b1}) begin
          n_err++;
          $display("FAIL rand_frame%0d: got %h p=%b stop=%b expected %h",
                   k, got, p, st, sent[k]);
        end
        k++;
        i += F1;
      end else begin
        i++;
      end
    end
    n_cmp++;
    if ({ok, k, cnt1, uf1} !== {1'b1, nb, 8'(exp_cnt1), 32'd0}) begin
      n_err++;
      $display("FAIL rand_total: ok=%b frames=%0d count=%0d uf=%0d expected 1 %0d %0d 0",
               ok, k, cnt1, uf1, nb, exp_cnt1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    en0 = 1'b0;
    en1 = 1'b0;
    test_reset;
    test_single;
    test_reset_mid;
    test_parity;
    test_back_to_back;
    test_enable_drop;
    test_wrap;
    test_random_parity;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for the byte FIFO. Pops one byte at a time whenever the FIFO is non-empty, then serializes it as an asynchronous UART frame on a single output pin.
- Frame format: start bit, 8 data bits LSB first, optional even parity bit, stop bit(s).
- Sits between the FIFO's read port and an output pin of the top-level wrapper.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit period; minimum 2.
PARITY_EN, 0, 1 = append an even-parity bit after the data bits.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
tx_enable  input  1  1 = allowed to start popping and sending new frames
fifo_empty  input  1  FIFO has no entries
fifo_data  input  8  FIFO registered read data; valid the cycle after fifo_rd_en
fifo_rd_en  output  1  one-cycle pop request to the FIFO
tx  output  1  UART serial line; idle high
busy  output  1  high in every state except IDLE
frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit
frame_count  output  8  number of completed frames; wraps modulo 256

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Outputs: tx=1, fifo_rd_en=0, busy=0, frame_done=0, frame_count=0.
  - Internal: state=IDLE, bit counter, cycle counter and shift register cleared.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If tx_enable=1 and fifo_empty=0, go to POP; otherwise stay.
- POP:
  - fifo_rd_en=1 for exactly this one cycle.
  - Next state LOAD unconditionally.
- LOAD:
  - Latch fifo_data into the shift register.
  - Compute the parity bit as the XOR of the 8 data bits.
  - Next state START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx = shift register bit 0, held for CLKS_PER_BIT cycles; then shift right.
  - After 8 bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = parity bit (even parity) for CLKS_PER_BIT cycles, then STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the last cycle: frame_done=1, and frame_count increments at the end of that cycle.
  - Then: if tx_enable=1 and fifo_empty=0, go directly to POP; else go to IDLE.
- Latency:
  - fifo_empty seen low in IDLE at cycle N -> fifo_rd_en high in cycle N+1 -> data latched in N+2 -> tx falls at cycle N+3.
  - Back-to-back frames: tx stays high for exactly 2 extra cycles (POP, LOAD) between the last stop cycle and the next start bit.
- Frame length: (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, measured from tx falling edge to end of the last stop bit.
- fifo_rd_en is never asserted while fifo_empty=1 is sampled. A FIFO underflow pop is impossible by construction.
- fifo_empty and fifo_data are ignored in every state except IDLE, POP→LOAD sampling, and STOP's final cycle.
- tx_enable deasserted mid-frame: the current frame completes normally; no further pop occurs.
- Reset asserted mid-frame: frame aborts immediately; tx returns high the same cycle; no frame_done pulse; frame_count returns to 0.
- frame_count wraps 255 -> 0 with no flag.
- tx_enable=1 with fifo_empty=1: remain in IDLE indefinitely; tx=1, busy=0.

Test Plan:
1. Reset with rst=1 mid-DATA, CLKS_PER_BIT=4 -> tx=1, busy=0, fifo_rd_en=0 within the same cycle; frame_count=0; no frame_done.
2. CLKS_PER_BIT=4, PARITY_EN=0: FIFO holds 0xA5, tx_enable=1 -> one fifo_rd_en pulse; tx falls 3 cycles after empty drops.
   - tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40-cycle frame).
   - frame_done pulses once; frame_count=1.
3. PARITY_EN=1, STOP_BITS=2, byte 0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit 1, then 8 cycles high; frame length 48 cycles.
4. FIFO preloaded with 0x11, 0x22, 0x33 -> three frames in order; exactly 2 extra idle-high cycles between frames; three rd_en pulses; frame_count=3; no pop after fifo_empty rises.
5. tx_enable dropped during DATA of the first of two queued bytes -> first frame completes; module returns to IDLE; no second rd_en until tx_enable=1 again.
6. Send 256 frames back-to-back -> frame_count wraps to 0 after frame 256; frame_done pulse count = 256.
